// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: FSM state encoding and default timing constants for pll_reset_ctrl
package pll_rst_pkg;
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;
  localparam int PLL_RST_CYCLES_DEF = 16;
  localparam int LOCK_TIMEOUT_DEF   = 250000;
  localparam int LOCK_STABLE_DEF    = 2500;
  localparam int CNT_W_DEF          = 18;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit, reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk) begin
    if (rst) {r_q, r_meta} <= 2'b00;
    else     {r_q, r_meta} <= {r_meta, i_d};
  end
  assign o_q = r_q;
endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset sequencer and lock-qualified system reset release.
// Optional fault_cnt status port enabled by PLL_RESET_CTRL_STATUS_EN.
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
  parameter int LOCK_STABLE    = LOCK_STABLE_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state
`ifdef PLL_RESET_CTRL_STATUS_EN
  ,
  output logic [7:0] fault_cnt
`endif
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst, r_sys_rst, r_ready;
  logic             w_lock_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock),
    .o_q (w_lock_s)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      RESET_PLL: w_next = (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: w_next = w_lock_s ? STABLE : (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) ? RESET_PLL : WAIT_LOCK;
      STABLE:    w_next = !w_lock_s ? WAIT_LOCK : (r_cnt == CNT_W'(LOCK_STABLE - 1)) ? RUN : STABLE;
      RUN:       w_next = w_lock_s ? RUN : RESET_PLL;
      default:   w_next = RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RESET_PLL;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_pll_rst <= (w_next == RESET_PLL);
      r_sys_rst <= (w_next != RUN);
      r_ready   <= (w_next == RUN);
    end
  end

  assign pll_rst = r_pll_rst;
  assign sys_rst = r_sys_rst;
  assign ready   = r_ready;
  assign state   = r_state;

`ifdef PLL_RESET_CTRL_STATUS_EN
  logic [7:0] r_fault_cnt;
  logic       w_fault;
  // Only a WAIT_LOCK timeout or a RUN lock-loss can lead back into RESET_PLL.
  assign w_fault = (r_state == WAIT_LOCK || r_state == RUN) && w_next == RESET_PLL;
  always_ff @(posedge clk) begin
    if (rst)                               r_fault_cnt <= '0;
    else if (w_fault && r_fault_cnt != '1) r_fault_cnt <= r_fault_cnt + 1'b1;
  end
  assign fault_cnt = r_fault_cnt;
`endif
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: lockstep reference-model bench for pll_reset_ctrl
module tb_pll_reset_ctrl;
  localparam int RC = 4;
  localparam int TO = 20;
  localparam int ST = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [1:0] state;
`ifdef PLL_RESET_CTRL_STATUS_EN
  logic [7:0] fault_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int ms = 0, mt = 0, mfc = 0;
  bit s1 = 1'b0, s2 = 1'b0;

  always #5 clk = ~clk;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES (RC),
    .LOCK_TIMEOUT   (TO),
    .LOCK_STABLE    (ST),
    .CNT_W          (18)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .pll_rst  (pll_rst),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .state    (state)
`ifdef PLL_RESET_CTRL_STATUS_EN
    ,
    .fault_cnt(fault_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: time-in-state plus a two-deep lock history, straight from the state rules.
  task automatic model_step(input bit lk, input bit r);
    int nx;
    if (r) begin
      ms = 0; mt = 0; mfc = 0; s1 = 0; s2 = 0;
      return;
    end
    nx = ms;
    if (ms == 0 && mt == RC - 1) nx = 1;
    else if (ms == 1 && s2) nx = 2;
    else if (ms == 1 && mt == TO - 1) begin nx = 0; if (mfc < 255) mfc++; end
    else if (ms == 2 && !s2) nx = 1;
    else if (ms == 2 && mt == ST - 1) nx = 3;
    else if (ms == 3 && !s2) begin nx = 0; if (mfc < 255) mfc++; end
    mt = (nx != ms) ? 0 : mt + 1;
    ms = nx;
    s2 = s1;
    s1 = lk;
  endtask

  task automatic tick(input bit lk, input bit r);
    pll_lock = lk;
    rst = r;
    @(posedge clk);
    model_step(lk, r);
    @(negedge clk);
    check("state", 32'(state), ms);
    check("pll_rst", 32'(pll_rst), 32'(ms == 0));
    check("sys_rst", 32'(sys_rst), 32'(ms != 3));
    check("ready", 32'(ready), 32'(ms == 3));
`ifdef PLL_RESET_CTRL_STATUS_EN
    check("fault_cnt", 32'(fault_cnt), mfc);
`endif
  endtask

  initial begin
    int hi, run_at, n, len, prev, seq;
    bit started, lk, rr;
    repeat (3) tick(0, 1);
    check("rst_state", 32'(state), 0);
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_sys_rst", 32'(sys_rst), 1);
    check("rst_ready", 32'(ready), 0);

    hi = 0; run_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (pll_rst) hi++;
      tick(i >= 10, 0);
      if (ready && run_at < 0) begin
        run_at = i;
        check("run_sys_rst_fall", 32'(sys_rst), 0);
      end
    end
    check("pll_rst_width", hi, RC);
    check("run_latency", run_at - 10 + 1, 2 + ST + 1);

    n = 0;
    while (!sys_rst && n < 10) begin tick(0, 0); n++; end
    check("loss_latency", n, 3);
    check("loss_pll_rst", 32'(pll_rst), 1);
    for (int i = 0; i < 40; i++) tick(1, 0);
    check("relock_ready", 32'(ready), 1);

    tick(0, 1);
    prev = 0; len = 0; started = 0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 0);
      if (int'(state) == prev) len++;
      else begin
        if (started) check(prev == 1 ? "wait_len" : "retry_len", len, prev == 1 ? TO : RC);
        started = 1; len = 1; prev = int'(state);
      end
    end

    tick(0, 1);
    while (ms != 1) tick(0, 0);
    seq = 1; prev = 1;
    for (int i = 0; i < 30; i++) begin
      tick(!(i == 5), 0);
      if (int'(state) != prev) begin seq = seq * 10 + int'(state); prev = int'(state); end
    end
    check("unstable_seq", seq, 12123);

    tick(0, 1);
    n = 0;
    while (ms != 2 && n < 20) begin tick(ms != 0, 0); n++; end
    check("reach_stable", ms, 2);
    tick(1, 1);
    check("midrst_state", 32'(state), 0);
    check("midrst_pll_rst", 32'(pll_rst), 1);
    check("midrst_sys_rst", 32'(sys_rst), 1);
`ifdef PLL_RESET_CTRL_STATUS_EN
    check("midrst_fault", 32'(fault_cnt), 0);
`endif

    n = 0;
    while (n < 3000) begin
      lk = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      rr = ($urandom_range(0, 40) == 0);
      for (int j = 0; j < len; j++) tick(lk, rr && j == 0);
      n += len;
    end

`ifdef PLL_RESET_CTRL_STATUS_EN
    tick(0, 1);
    repeat (300 * (TO + RC) + 10) tick(0, 0);
    check("fault_sat", 32'(fault_cnt), 255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
